// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle divider.
// FSM state encoding plus named ready/start levels used by div and its bench.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div.sv
// Restoring divider, one quotient bit per cycle, signed/unsigned, with annul.
// Handshake: start_i stays high until ready_o is seen; ready_o holds in END until start_i drops.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    div_state_e         state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   rem, rem_n;
    logic [WIDTH-1:0]   quo, quo_n;
    logic [WIDTH-1:0]   dvsr, dvsr_n;
    logic               neg_q, neg_q_n;
    logic               neg_r, neg_r_n;
    logic [2*WIDTH-1:0] result_n;
    logic               ready_n;

    // Magnitudes of the operands as seen at latch time
    logic               op1_neg, op2_neg;
    logic [WIDTH-1:0]   op1_abs, op2_abs;

    // One restoring step: shift in the next dividend bit, trial-subtract
    logic [WIDTH:0]     shifted, trial;
    logic               fits;
    logic [WIDTH-1:0]   q_fin, r_fin;

    always_comb begin
        op1_neg = signed_div_i & opdata1_i[WIDTH-1];
        op2_neg = signed_div_i & opdata2_i[WIDTH-1];
        op1_abs = op1_neg ? -opdata1_i : opdata1_i;
        op2_abs = op2_neg ? -opdata2_i : opdata2_i;

        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr};
        fits    = (shifted >= {1'b0, dvsr});

        q_fin = neg_q ? -quo : quo;
        r_fin = neg_r ? -rem : rem;
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rem_n    = rem;
        quo_n    = quo;
        dvsr_n   = dvsr;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        result_n = result_o;
        ready_n  = ready_o;

        case (state)
            DIV_FREE: begin
                ready_n  = DIV_RESULT_NOT_READY;
                result_n = '0;
                if (start_i == DIV_START && !annul_i) begin
                    cnt_n = '0;
                    rem_n = '0;
                    if (opdata2_i == '0) begin
                        state_n = DIV_BY_ZERO;
                        quo_n   = '0;
                        dvsr_n  = '0;
                        neg_q_n = 1'b0;
                        neg_r_n = 1'b0;
                    end else begin
                        state_n = DIV_ON;
                        quo_n   = op1_abs;
                        dvsr_n  = op2_abs;
                        neg_q_n = op1_neg ^ op2_neg;
                        neg_r_n = op1_neg;
                    end
                end
            end

            DIV_BY_ZERO: begin
                rem_n = '0;
                quo_n = '0;
                state_n = annul_i ? DIV_FREE : DIV_END;
            end

            DIV_ON: begin
                if (annul_i) begin
                    state_n = DIV_FREE;
                end else if (cnt == CNT_LAST) begin
                    state_n  = DIV_END;
                    ready_n  = DIV_RESULT_READY;
                    result_n = {r_fin, q_fin};
                end else begin
                    rem_n = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo_n = {quo[WIDTH-2:0], fits};
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            DIV_END: begin
                // Divide-by-zero arrives here with ready low; raise it with the zero result
                if (start_i == DIV_START) begin
                    ready_n = DIV_RESULT_READY;
                end else begin
                    state_n  = DIV_FREE;
                    ready_n  = DIV_RESULT_NOT_READY;
                    result_n = '0;
                end
            end

            default: state_n = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rem      <= rem_n;
            quo      <= quo_n;
            dvsr     <= dvsr_n;
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed and randomized checks of div (WIDTH=32) against an arithmetic reference.
module tb_div;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           signed_div_i = 1'b0;
    logic [W-1:0]   opdata1_i = '0;
    logic [W-1:0]   opdata2_i = '0;
    logic           start_i = 1'b0;
    logic           annul_i = 1'b0;
    logic [2*W-1:0] result_o;
    logic           ready_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {remainder, quotient} from plain integer arithmetic; zero divisor yields zero
    function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
        longint x, y, q, r;
        if (b == '0) return 64'd0;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input int hold);
        logic [63:0] exp;
        int          lat;
        int          exp_lat;
        logic        got;
        exp     = model(a, b, s);
        exp_lat = (b == '0) ? 2 : W + 1;
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        @(posedge clk);
        // Operand inputs wiggle after acceptance; the latched copies must be used
        #2;
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready_o) got = 1'b1;
        end
        check({tag, " ready"}, 64'(got), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, result_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            annul_i = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check({tag, " hold ready"}, 64'(ready_o), 64'd1);
            check({tag, " hold result"}, result_o, exp);
        end
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " drop ready"}, 64'(ready_o), 64'd0);
        check({tag, " drop result"}, result_o, 64'd0);
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic         s;
        logic         seen;

        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div("u100_7", 32'd100, 32'd7, 1'b0, 1);
        check("u100_7 model", model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        run_div("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        run_div("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        run_div("byzero", 32'h1234_5678, 32'd0, 1'b0, 2);
        run_div("minint", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5);
        run_div("umax", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);

        // Annul mid-division: no result may appear
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk);
        #1;
        check("annul ready", 64'(ready_o), 64'd0);
        check("annul result", result_o, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1'b1;
        end
        check("annul no ready", 64'(seen), 64'd0);
        run_div("after_annul", 32'd9, 32'd3, 1'b0, 0);

        // Reset mid-division, with start still requested in the reset cycle
        @(negedge clk);
        opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; annul_i = 1'b0;
        @(posedge clk);
        #1;
        check("rst ready", 64'(ready_o), 64'd0);
        check("rst result", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("rst hold ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div("after_rst", 32'd1000, 32'd3, 1'b0, 0);

        for (int k = 0; k < 20; k++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            run_div($sformatf("rand%0d", k), a, b, s, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width; result_o is 2*WIDTH bits.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high (`RESET_ENABLE); sampled on clk rising edge.
REQ-004 SHALL have port signed_div_i  input  1  1 = signed division (DIV), 0 = unsigned (DIVU).
REQ-005 SHALL have port opdata1_i  input  WIDTH  dividend.
REQ-006 SHALL have port opdata2_i  input  WIDTH  divisor.
REQ-007 SHALL have port start_i  input  1  start request from EX; held high until ready_o is seen.
REQ-008 SHALL have port annul_i  input  1  cancel the in-flight division (branch/flush).
REQ-009 SHALL have port result_o  output  2*WIDTH  {remainder, quotient}; registered.
REQ-010 SHALL have port ready_o  output  1  result_o is valid this cycle; registered.

Function
REQ-011 SHALL implement a four-state FSM: FREE, BY_ZERO, ON, END.
REQ-012 In FREE with start_i=1 and annul_i=0: divisor==0 -> BY_ZERO, else -> ON, iteration counter cleared to 0, operands latched.
REQ-013 In FREE with start_i=0 or annul_i=1: remain FREE; ready_o=0; result_o=0.
REQ-014 BY_ZERO SHALL go to END on the next edge with the latched result forced to 0.
REQ-015 ON SHALL perform one restoring-division step per cycle (shift partial remainder, trial-subtract divisor, set quotient bit), incrementing the counter 0..WIDTH.
REQ-016 When the counter equals WIDTH in ON, the FSM SHALL go to END with result_o = {remainder, quotient}, ready_o=1.
REQ-017 Latency: start sampled at edge E0 -> ready_o=1 after edge E0+WIDTH+1 (33 for WIDTH=32); divide-by-zero -> after edge E0+2.
REQ-018 Signed mode: operands replaced by absolute values at latch; quotient negated if operand signs differ; remainder carries dividend's sign.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0 (no trap).
REQ-020 annul_i=1 in ON or BY_ZERO SHALL force FREE on the next edge; ready_o stays 0; no result produced.
REQ-021 start_i, opdata*_i and signed_div_i changes while in ON SHALL be ignored (latched copies used).
REQ-022 END SHALL hold ready_o=1 and result_o stable while start_i=1; start_i=0 in END -> FREE, ready_o=0, result_o=0 next edge.
REQ-023 annul_i in END SHALL be ignored; only start_i controls leaving END.
REQ-024 A new start_i pulse SHALL be accepted no earlier than the first cycle in FREE after END (no back-to-back without one FREE cycle).

Reset
REQ-025 rst=1 at any edge, any state (including mid-ON), SHALL force FREE, counter 0, result_o=0, ready_o=0, latched operands 0.
REQ-026 rst SHALL take priority over start_i and annul_i in the same cycle.

Structure
REQ-027 State encodings (DivFree, DivByZero, DivOn, DivEnd), DivResultReady/NotReady, DivStart/Stop SHALL be `define constants in const.v.
REQ-028 SHALL be a single module with no sub-module; EX instantiates it and drives the stall request from start_i & ~ready_o.

Verification
REQ-029 Unsigned 100 / 7, start at E0 -> ready_o=1 after E0+33, result_o = {0x00000002, 0x0000000E}.
REQ-030 Signed -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-031 Divisor 0, dividend 0x12345678 -> ready_o=1 after E0+2, result_o=0.
REQ-032 annul_i pulsed at counter=10 -> FREE next edge, ready_o never asserts; following start 9/3 -> quotient 3, remainder 0 after 33 cycles.
REQ-033 Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}; start_i held 5 extra cycles -> ready_o and result_o stable, then 0 one edge after start_i drops.
REQ-034 rst asserted at counter=20 -> FREE, ready_o=0, result_o=0 next edge; subsequent division correct.
